// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for conv2d_top: streams IN_CHANNELS planes of IMAGE_HEIGHT x IMAGE_WIDTH
// pixels, framing each plane with pad_top/pad_bottom, a pipeline drain and next_channel.
module conv_frame_sequencer #(
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 10,
  parameter int IN_CHANNELS  = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int DRAIN_CYCLES = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_frame,
  input  logic                         abort,
  input  logic                         s_valid,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic                         s_ready,
  output logic                         conv_valid_in,
  output logic signed [DATA_WIDTH-1:0] conv_pixel_in,
  output logic                         conv_pad_top,
  output logic                         conv_pad_bottom,
  output logic                         conv_start,
  output logic                         conv_next_channel,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int CW  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int CHW = (IN_CHANNELS  > 1) ? $clog2(IN_CHANNELS)  : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CW-1:0]  COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(IN_CHANNELS - 1);
  localparam logic [DCW-1:0] DRN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, STREAM, PAD_BOT, DRAIN, NEXT_CH, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [CHW-1:0] ch;
  logic [DCW-1:0] dcnt;
  logic           xfer;

  assign s_ready = (state == STREAM);
  assign busy    = (state != IDLE);
  assign xfer    = s_valid && s_ready;

  // Strobes are registered on the edge that leaves their state, so each lands one
  // cycle after the state it belongs to and they can never overlap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      col               <= '0;
      row               <= '0;
      ch                <= '0;
      dcnt              <= '0;
      conv_pixel_in     <= '0;
      conv_valid_in     <= 1'b0;
      conv_pad_top      <= 1'b0;
      conv_pad_bottom   <= 1'b0;
      conv_start        <= 1'b0;
      conv_next_channel <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      conv_valid_in     <= 1'b0;
      conv_pad_top      <= 1'b0;
      conv_pad_bottom   <= 1'b0;
      conv_start        <= 1'b0;
      conv_next_channel <= 1'b0;
      frame_done        <= 1'b0;
      if (abort && state != IDLE) begin
        // abort wins even over a last-pixel transfer in the same cycle
        state <= IDLE;
        col   <= '0;
        row   <= '0;
        ch    <= '0;
        dcnt  <= '0;
      end else begin
        case (state)
          IDLE: if (start_frame && !abort) begin
            conv_start <= 1'b1;
            col        <= '0;
            row        <= '0;
            ch         <= '0;
            state      <= STREAM;
          end
          STREAM: if (xfer) begin
            conv_valid_in <= 1'b1;
            conv_pixel_in <= s_data;
            conv_pad_top  <= (row == '0) && (col == '0);
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= PAD_BOT;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
          PAD_BOT: begin
            conv_pad_bottom <= 1'b1;
            dcnt            <= '0;
            state           <= DRAIN;
          end
          DRAIN: begin
            if (dcnt == DRN_LAST) state <= (ch == CH_LAST) ? DONE : NEXT_CH;
            else                  dcnt  <= dcnt + 1'b1;
          end
          NEXT_CH: begin
            conv_next_channel <= 1'b1;
            ch                <= ch + 1'b1;
            col               <= '0;
            row               <= '0;
            state             <= STREAM;
          end
          DONE: begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer at W=4, H=3, C=2, DRAIN=5, with a timeline
// model of the expected per-cycle strobes and pixel values.
module tb_conv_frame_sequencer;
  localparam int W = 4, H = 3, C = 2, D = 5, DW = 16;

  logic clk = 1'b0, rst = 1'b0, start_frame = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic s_ready, conv_valid_in, conv_pad_top, conv_pad_bottom, conv_start;
  logic conv_next_channel, busy, frame_done;
  logic signed [DW-1:0] conv_pixel_in;
  logic [7:0] obs;

  int n_chk = 0, n_err = 0;
  logic [7:0] e_flag [64];
  int         e_data [64];
  int         e_last;
  int         d;
  logic       seen;

  conv_frame_sequencer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .IN_CHANNELS(C), .DATA_WIDTH(DW), .DRAIN_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .start_frame(start_frame), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .conv_valid_in(conv_valid_in), .conv_pixel_in(conv_pixel_in),
    .conv_pad_top(conv_pad_top), .conv_pad_bottom(conv_pad_bottom),
    .conv_start(conv_start), .conv_next_channel(conv_next_channel),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // {start, valid, pad_top, pad_bottom, next_channel, done, ready, busy}
  assign obs = {conv_start, conv_valid_in, conv_pad_top, conv_pad_bottom,
                conv_next_channel, frame_done, s_ready, busy};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Cycle k = k-th cycle after the start_frame edge; stall inserts sl idle STREAM cycles
  // before pixel sp of channel 0.
  task automatic build_model(input int sp, input int sl);
    int t = 0;
    for (int i = 0; i < 64; i++) begin e_flag[i] = '0; e_data[i] = 0; end
    e_flag[0][7] = 1'b1;
    for (int c = 0; c < C; c++) begin
      for (int p = 0; p < W*H; p++) begin
        if (c == 0 && p == sp)
          for (int s = 0; s < sl; s++) begin e_flag[t][1:0] = 2'b11; t++; end
        e_flag[t][1:0]   = 2'b11;
        e_flag[t+1][6]   = 1'b1;
        e_flag[t+1][5]   = (p == 0);
        e_data[t+1]      = p / W + p % W;
        t++;
      end
      e_flag[t][0] = 1'b1; e_flag[t+1][4] = 1'b1; t++;
      for (int k = 0; k < D; k++) begin e_flag[t][0] = 1'b1; t++; end
      if (c < C-1) begin e_flag[t][0] = 1'b1; e_flag[t+1][3] = 1'b1; t++; end
    end
    e_flag[t][0] = 1'b1; e_flag[t+1][2] = 1'b1;
    e_last = t + 1;
  endtask

  task automatic run_frame(input int sp, input int sl, input int extra, output int done_at);
    int idx = 0, chn = 0, sc = 0;
    done_at = -1;
    build_model(sp, sl);
    @(negedge clk); start_frame = 1'b1; s_valid = 1'b1; s_data = '0;
    @(negedge clk); start_frame = 1'b0;
    for (int k = 0; k <= e_last + 2; k++) begin
      if (k > 0) @(negedge clk);
      start_frame = (k == extra);
      chk($sformatf("flags@%0d", k), 32'(obs), 32'(e_flag[k]));
      if (e_flag[k][6]) chk($sformatf("pixel@%0d", k), 32'(conv_pixel_in), e_data[k]);
      if (frame_done && done_at < 0) done_at = k;
      s_data = DW'(idx / W + idx % W);
      if (s_ready && chn == 0 && idx == sp && sc < sl) begin
        s_valid = 1'b0; sc++;
      end else begin
        s_valid = 1'b1;
        if (s_ready) begin
          idx++;
          if (idx == W*H) begin idx = 0; chn++; end
        end
      end
    end
    start_frame = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_flags", 32'(obs), 0);
    chk("reset_pixel", 32'(conv_pixel_in), 0);
    @(negedge clk); rst = 1'b1;

    run_frame(-1, 0, -1, d);
    chk("cont_done_cycle", d, 38);

    run_frame(6, 3, -1, d);
    chk("stall_done_cycle", d, 41);

    run_frame(-1, 0, 15, d);
    chk("busy_start_done_cycle", d, 38);

    // abort together with the final pixel of channel 0
    @(negedge clk); start_frame = 1'b1; s_valid = 1'b1; s_data = 16'sd9;
    @(negedge clk); start_frame = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort_pre_ready", 32'(s_ready), 1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_flags", 32'(obs), 0);
    seen = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (frame_done || conv_pad_bottom || busy) seen = 1'b1;
    end
    chk("abort_quiet", 32'(seen), 0);

    start_frame = 1'b1; abort = 1'b1;
    @(negedge clk); start_frame = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 32'(obs), 0);

    // reset pulse mid-STREAM of channel 1
    s_data = 16'sd7;
    @(negedge clk); start_frame = 1'b1;
    @(negedge clk); start_frame = 1'b0;
    repeat (22) @(negedge clk);
    chk("rst_pre_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_flags", 32'(obs), 0);
    chk("rst_async_pixel", 32'(conv_pixel_in), 0);
    @(negedge clk); rst = 1'b1;
    run_frame(-1, 0, -1, d);
    chk("rst_restart_done_cycle", d, 38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
